pipe_stage_buf: RTL



---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_entry.sv | 54 +++++
 rtl/pipe_stage_buf.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-boundary stage buffers.
// Holds state encodings, exception/reset vectors and per-stage payload widths.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  // Payload widths as concatenated by each instantiating stage
  localparam int D_PAYLOAD_W = 96;
  localparam int E_PAYLOAD_W = 96;
  localparam int M_PAYLOAD_W = 96;
  localparam int W_PAYLOAD_W = 96;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry register: {valid, data, pc, bd}.
// Clear writes a bubble and takes priority over load; drop only clears valid.
module pipe_entry #(
  parameter int          DATA_W   = 96,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              drop_i,
  input  logic [31:0]       bubblePc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [31:0]       pc_i,
  input  logic              bd_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [31:0]       pc_o,
  output logic              bd_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [31:0]       pc_q;
  logic              bd_q;

  // Drop keeps payload/PC/BD so the last beat stays visible while idle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= bubblePc_i;
      bd_q    <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
      bd_q    <= bd_i;
    end else if (drop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign bd_o    = bd_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic pipeline boundary with valid/ready handshake and a 2-entry skid buffer.
// in_ready comes from the skid valid register, so a downstream stall never reaches upstream combinationally.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = D_PAYLOAD_W,
  parameter logic [31:0] EXC_PC   = EXC_VEC,
  parameter logic [31:0] RESET_PC = RESET_VEC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  input  logic              in_bd,
  input  logic              flush,
  input  logic              req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic              out_bd,
  output logic [1:0]        occupancy
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              inHs;
  logic              outHs;
  logic              mainLoad;
  logic              mainDrop;
  logic              mainFromSkid;
  logic              skidLoad;
  logic              skidDrop;
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic [31:0]       skidPc;
  logic              skidBd;
  logic [DATA_W-1:0] mainDataIn;
  logic [31:0]       mainPcIn;
  logic              mainBdIn;
  logic [31:0]       flushPc;

  assign inHs    = in_valid & in_ready;
  assign outHs   = out_valid & out_ready;
  assign flushPc = req ? EXC_PC : RESET_PC;

  // Flush overrides everything, including a same-cycle input or output handshake
  always_comb begin
    state_d      = state_q;
    mainLoad     = 1'b0;
    mainDrop     = 1'b0;
    mainFromSkid = 1'b0;
    skidLoad     = 1'b0;
    skidDrop     = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (inHs) begin
            mainLoad = 1'b1;
            state_d  = ST_FULL;
          end
        end
        ST_FULL: begin
          if (inHs && outHs) begin
            mainLoad = 1'b1;
          end else if (inHs) begin
            skidLoad = 1'b1;
            state_d  = ST_SKID;
          end else if (outHs) begin
            mainDrop = 1'b1;
            state_d  = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (outHs) begin
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidDrop     = 1'b1;
            state_d      = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign mainDataIn = mainFromSkid ? skidData : in_data;
  assign mainPcIn   = mainFromSkid ? skidPc   : in_pc;
  assign mainBdIn   = mainFromSkid ? skidBd   : in_bd;

  pipe_entry #(
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC)
  ) uMain (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (mainLoad),
    .clear_i   (flush),
    .drop_i    (mainDrop),
    .bubblePc_i(flushPc),
    .data_i    (mainDataIn),
    .pc_i      (mainPcIn),
    .bd_i      (mainBdIn),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .pc_o      (out_pc),
    .bd_o      (out_bd)
  );

  pipe_entry #(
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC)
  ) uSkid (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (skidLoad),
    .clear_i   (flush),
    .drop_i    (skidDrop),
    .bubblePc_i(RESET_PC),
    .data_i    (in_data),
    .pc_i      (in_pc),
    .bd_i      (in_bd),
    .valid_o   (skidValid),
    .data_o    (skidData),
    .pc_o      (skidPc),
    .bd_o      (skidBd)
  );

  assign in_ready  = ~skidValid;
  assign occupancy = state_q;

endmodule
